alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU. Each cycle it captures the ALU result word (OUT) together with the opcode that produced it.
- Generates the status flags N, Z, C and V from the captured result and ALU side-band signals.
- Buffers up to two results in a skid buffer and presents them to the consumer (register-file writeback / flag register) over a valid/ready handshake.
- Decouples ALU timing from consumer backpressure without dropping results.

Parameters:
- Nbits, 5, datapath width; must equal the ALU Nbits.
- OPW, 4, opcode width; fixed at 4 to match ALU op select.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- alu_out  input  Nbits  ALU OUT word.
- alu_op  input  OPW  opcode that produced alu_out.
- alu_carry  input  1  raw carry-out from adder path.
- alu_ovf  input  1  raw signed overflow from adder path.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry this cycle.
- result  output  Nbits  head entry result.
- op  output  OPW  head entry opcode.
- flags  output  4  head entry flags {N,Z,C,V}, bit3=N … bit0=V.
- op_illegal  output  1  head entry opcode outside 0000..1001.
- ovf_sticky  output  1  sticky overflow; set when a popped entry has V=1.
- clr_sticky  input  1  clears ovf_sticky.

Behaviour:
- Reset: synchronous, active-high. While rst=1 at a clock edge:
  - occupancy:=0, out_valid:=0, result:=0, op:=0, flags:=0, op_illegal:=0, ovf_sticky:=0.
  - in_ready is 0 during any cycle rst is high.
  - Reset mid-transfer discards both entries; nothing is popped.
- Storage: 2-entry FIFO (head, tail) with a 2-bit occupancy count 0..2.
  - in_ready = !rst && (count != 2), derived from registered count only; no combinational path from out_ready.
- Push: in_valid && in_ready at a rising edge.
  - The entry {alu_out, alu_op, flags, illegal} is written.
  - It becomes visible on the outputs after that edge when the FIFO was empty, giving 1-cycle latency.
- Pop: out_valid && out_ready at a rising edge. The head is removed and the tail moves to the head.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes the head.
  - count=0: only the push takes effect (out_valid was 0).
  - count=2: no push, since in_ready=0.
- Outputs when empty: out_valid=0; result/op/flags/op_illegal hold the last popped values. They are don't-care for the consumer.
- Flag generation at push time, from alu_out and alu_op:
  - Z = (alu_out == 0).
  - N = alu_out[Nbits-1].
  - C = alu_carry when op is ADD(0000) or SUB(0001), else 0.
  - V = alu_ovf when op is ADD or SUB, else 0.
  - op_illegal = alu_op > 1001. Z and N are still computed; C=V=0.
- Sticky overflow:
  - Set on a pop whose head has V=1.
  - Cleared when clr_sticky=1.
  - clr_sticky and a V=1 pop in the same cycle leave the flag set; set wins.
- Order: strict FIFO, no reordering, no drops, no duplication.

Decomposition:
- Package alu_pkg holds:
  - Opcode enum: ADD=0000, SUB=0001, AND=0010, OR=0011, NOT=0100, XOR=0101, SRL=0110, SLL=0111, SRA=1000, SLA=1001.
  - OP_LAST constant = 1001.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Packed struct for a buffer entry.
- Sub-module alu_flag_gen (combinational: alu_out, alu_op, alu_carry, alu_ovf -> flags, op_illegal), reused by the later status register.

Test Plan (Nbits=5):
- Basic latency: reset, then push alu_out=5'b00110, op=SLL, carry=1, with out_ready=1 -> next cycle out_valid=1, result=00110, flags=0000 (C masked for SLL).
- Zero/negative on ADD: push {00000, ADD, carry=1, ovf=0} -> flags=0110. Push {10000, SUB, carry=0, ovf=1} -> flags=1001.
- Backpressure: out_ready=0, push three results A,B,C on consecutive cycles -> A and B accepted, in_ready=0 on the third cycle. Raise out_ready -> A, B, then C after it is re-presented, in order.
- Simultaneous push/pop at count=1: steady in_valid=out_ready=1 for 10 cycles with incrementing data -> count stays 1, one result per cycle, no gaps.
- Illegal op and sticky: push {00001, 1111} -> op_illegal=1, flags=0000. Pop an ADD with ovf=1 -> ovf_sticky=1 next cycle. clr_sticky alone -> 0. clr_sticky concurrent with another V=1 pop -> stays 1.
- Reset mid-operation: with count=2, assert rst one cycle -> out_valid=0, in_ready=0 during rst, in_ready=1 after. The old entries never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag and buffer-entry definitions for the ALU result path.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_NOT = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRA = 4'b1000,
    OP_SLA = 4'b1001
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_LAST = 4'b1001;

  // Side-band part of a buffer entry; the result word sits beside it because
  // its width is a per-instance parameter.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [FLAG_W-1:0] flags;
    logic              illegal;
  } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V and illegal-opcode decode for one ALU result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned Nbits = 5
) (
  input  logic [Nbits-1:0]  alu_out,
  input  logic [OP_W-1:0]   alu_op,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic [FLAG_W-1:0] flags,
  output logic              op_illegal
);

  logic is_arith;

  // Carry and overflow only mean something on the adder path.
  always_comb begin
    is_arith   = (alu_op == OP_W'(OP_ADD)) || (alu_op == OP_W'(OP_SUB));
    op_illegal = (alu_op > OP_LAST);
    flags      = {alu_out[Nbits-1],
                  (alu_out == '0),
                  is_arith & alu_carry,
                  is_arith & alu_ovf};
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag capture plus a 2-entry skid buffer toward
// the writeback/flag consumer, with a sticky overflow bit on popped results.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned Nbits = 5,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Nbits-1:0] alu_out,
  input  logic [OPW-1:0]   alu_op,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] result,
  output logic [OPW-1:0]   op,
  output logic [3:0]       flags,
  output logic             op_illegal,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [Nbits-1:0]  head_res_q, head_res_d;
  logic [Nbits-1:0]  tail_res_q, tail_res_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  entry_t            new_entry;
  logic              valid_q, valid_d;
  logic              sticky_q, sticky_d;
  logic [FLAG_W-1:0] new_flags;
  logic              new_illegal;
  logic              push, pop;

  alu_flag_gen #(.Nbits(Nbits)) u_flag_gen (
    .alu_out    (alu_out),
    .alu_op     (alu_op),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .flags      (new_flags),
    .op_illegal (new_illegal)
  );

  assign new_entry = '{op: alu_op, flags: new_flags, illegal: new_illegal};

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready = !rst && (count_q != CNT_W'(2));
  assign push     = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    head_res_d = head_res_q;
    tail_d     = tail_q;
    tail_res_d = tail_res_q;
    sticky_d   = sticky_q;

    case (count_q)
      CNT_W'(0): begin
        if (push) begin
          head_d     = new_entry;
          head_res_d = alu_out;
          count_d    = CNT_W'(1);
        end
      end
      CNT_W'(1): begin
        if (push && pop) begin
          head_d     = new_entry;
          head_res_d = alu_out;
        end else if (push) begin
          tail_d     = new_entry;
          tail_res_d = alu_out;
          count_d    = CNT_W'(2);
        end else if (pop) begin
          // Head keeps the popped values; they are don't-care while empty.
          count_d = CNT_W'(0);
        end
      end
      CNT_W'(2): begin
        if (pop) begin
          head_d     = tail_q;
          head_res_d = tail_res_q;
          count_d    = CNT_W'(1);
        end
      end
      default: count_d = CNT_W'(0);
    endcase

    valid_d = (count_d != CNT_W'(0));

    // A V=1 pop beats a concurrent clear.
    if (pop && head_q.flags[FLAG_V]) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      head_res_q <= '0;
      tail_q     <= '0;
      tail_res_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      head_res_q <= head_res_d;
      tail_q     <= tail_d;
      tail_res_q <= tail_res_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign result     = head_res_q;
  assign op         = head_q.op;
  assign flags      = head_q.flags;
  assign op_illegal = head_q.illegal;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random checks of alu_result_stage against a queue-based model.
module tb_alu_result_stage;

  localparam int unsigned NB = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] alu_out;
  logic [3:0]    alu_op;
  logic          alu_carry;
  logic          alu_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] result;
  logic [3:0]    op;
  logic [3:0]    flags;
  logic          op_illegal;
  logic          ovf_sticky;
  logic          clr_sticky;

  alu_result_stage #(.Nbits(NB), .OPW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .alu_op     (alu_op),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .op         (op),
    .flags      (flags),
    .op_illegal (op_illegal),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] res;
    logic [3:0] op;
    logic [3:0] flags;
    logic       ill;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic sticky_m;
  int   vectors;
  int   miscompares;

  function automatic exp_t model_entry(logic [4:0] o, logic [3:0] c, logic cy, logic ov);
    exp_t e;
    logic arith;
    arith   = (c == 4'd0) || (c == 4'd1);
    e.res   = o;
    e.op    = c;
    e.ill   = (c > 4'd9);
    e.flags = {o[4], (o == 5'd0), arith & cy, arith & ov};
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] o, logic [3:0] c, logic cy, logic ov);
    in_valid  = v;
    alu_out   = o;
    alu_op    = c;
    alu_carry = cy;
    alu_ovf   = ov;
  endtask

  // One clock: check ready, advance model and DUT, then check the head.
  task automatic cycle(output logic pushed);
    logic push, pop, clr;
    exp_t e, h;
    #1;
    check("in_ready", 32'(in_ready), 32'(!rst && q.size() != 2));
    push = !rst && in_valid && (q.size() != 2);
    pop  = !rst && out_ready && (q.size() != 0);
    clr  = clr_sticky;
    e    = model_entry(alu_out, alu_op, alu_carry, alu_ovf);
    @(posedge clk);
    if (rst) begin
      q.delete();
      last     = '{default: 0};
      sticky_m = 1'b0;
    end else begin
      if (pop) begin
        last = q.pop_front();
        if (last.flags[0]) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
      end else if (clr) begin
        sticky_m = 1'b0;
      end
      if (push) q.push_back(e);
    end
    pushed = push;
    #1;
    h = (q.size() != 0) ? q[0] : last;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("result", 32'(result), 32'(h.res));
    check("op", 32'(op), 32'(h.op));
    check("flags", 32'(flags), 32'(h.flags));
    check("op_illegal", 32'(op_illegal), 32'(h.ill));
    check("ovf_sticky", 32'(ovf_sticky), 32'(sticky_m));
  endtask

  initial begin
    logic p;
    vectors     = 0;
    miscompares = 0;
    last        = '{default: 0};
    sticky_m    = 1'b0;
    rst         = 1'b1;
    out_ready   = 1'b1;
    clr_sticky  = 1'b0;
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);

    // Reset
    cycle(p);
    cycle(p);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    // Basic latency: SLL masks carry
    drive(1'b1, 5'b00110, 4'b0111, 1'b1, 1'b0);
    cycle(p);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_result", 32'(result), 32'h06);
    check("lat_flags", 32'(flags), 32'h0);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    cycle(p);

    // Zero / negative on the adder path
    drive(1'b1, 5'b00000, 4'd0, 1'b1, 1'b0);
    cycle(p);
    check("zero_add_flags", 32'(flags), 32'b0110);
    drive(1'b1, 5'b10000, 4'd1, 1'b0, 1'b1);
    cycle(p);
    check("neg_sub_flags", 32'(flags), 32'b1001);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    cycle(p);
    check("sub_pop_sticky", 32'(ovf_sticky), 32'd1);
    clr_sticky = 1'b1;
    cycle(p);
    clr_sticky = 1'b0;

    // Backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    drive(1'b1, 5'h0A, 4'd2, 1'b0, 1'b0);
    cycle(p);
    drive(1'b1, 5'h0B, 4'd3, 1'b0, 1'b0);
    cycle(p);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 5'h0C, 4'd5, 1'b0, 1'b0);
    cycle(p);
    check("bp_head_A", 32'(result), 32'h0A);
    out_ready = 1'b1;
    cycle(p);
    check("bp_head_B", 32'(result), 32'h0B);
    cycle(p);
    check("bp_head_C", 32'(result), 32'h0C);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    cycle(p);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Steady push/pop at occupancy 1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 1), 4'd2, 1'b0, 1'b0);
      cycle(p);
      check("steady_result", 32'(result), 32'(i + 1));
      check("steady_in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    cycle(p);

    // Illegal opcode and sticky overflow
    drive(1'b1, 5'b00001, 4'hF, 1'b1, 1'b1);
    cycle(p);
    check("illegal_flag", 32'(op_illegal), 32'd1);
    check("illegal_flags", 32'(flags), 32'h0);
    drive(1'b1, 5'd3, 4'd0, 1'b0, 1'b1);
    cycle(p);
    check("sticky_not_yet", 32'(ovf_sticky), 32'd0);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    cycle(p);
    check("sticky_set", 32'(ovf_sticky), 32'd1);
    clr_sticky = 1'b1;
    cycle(p);
    check("sticky_clr", 32'(ovf_sticky), 32'd0);
    clr_sticky = 1'b0;
    drive(1'b1, 5'd7, 4'd0, 1'b0, 1'b1);
    cycle(p);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    cycle(p);
    check("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    clr_sticky = 1'b0;

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 5'h11, 4'd4, 1'b0, 1'b0);
    cycle(p);
    drive(1'b1, 5'h12, 4'd6, 1'b0, 1'b0);
    cycle(p);
    drive(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(p);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(p);
      check("postrst_no_ghost", 32'(out_valid), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      drive(1'($urandom), 5'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom));
      cycle(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
